pe_ctrl: RTL and testbench
==========================

PE_CTRL -- requirements
Module: pe_ctrl

Interface
REQ-001 Parameter: LEN_W, default 16, width of the job beat-count field.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  job request.
- cfg_ready  out  1  job accepted when high together with cfg_valid.
- cfg_mode  in  2  precision: 0=2b, 1=4b, 2=8b; 3 is reserved.
- cfg_x_signed, cfg_y_signed  in  1 each  operand signedness.
- cfg_len  in  LEN_W  number of beats minus 1.
- in_valid / in_ready  in / out  1  operand stream handshake.
- in_x, in_y  in  32  packed operand beat.
- pe_x, pe_y  out  32  operands to the fusion unit.
- pe_sign_x, pe_sign_y  out  4  per-brick-row sign controls.
- pe_signal  out  32  shift controls.
- pe_sum_signal  out  8  adder-tree controls.
- pe_previous_sum  out  20  accumulator feedback.
- pe_sum  in  20  fusion unit result, valid 1 cycle after issue.
- out_valid / out_ready  out / in  1  result handshake.
- out_sum  out  20  final dot-product sum.
- busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-003 FSM states are IDLE, RUN, DRAIN and DONE.
REQ-004 IDLE: cfg_ready=1; on cfg_valid the block latches mode, signs and len, clears the beat counter, and goes to RUN. Mode 3 is accepted and treated as mode 2.
REQ-005 RUN: in_ready=1; each in_valid&in_ready beat registers in_x/in_y onto pe_x/pe_y and increments the beat counter. The beat with counter==len goes to DRAIN.
REQ-006 Back-to-back beats (one per cycle) are sustained; in_valid low inserts a bubble, and a bubble never updates the accumulator.
REQ-007 The issue-valid flag is delayed 1 cycle (beat_d) to match fusion-unit latency. On a cycle with beat_d high, acc <= pe_sum.
REQ-008 pe_previous_sum is 0 when beat_d marks the first beat of a job, and acc otherwise.
REQ-009 DRAIN lasts exactly 1 cycle, capturing the last pe_sum into acc, then goes to DONE.
REQ-010 DONE: out_valid=1 and out_sum=acc, both held stable until out_ready. On the out_valid&out_ready cycle the FSM goes to IDLE, and cfg_ready rises the next cycle.
REQ-011 pe_signal and pe_sum_signal are constant for the whole job and come from package LUTs indexed by mode. 2b mode drives all zeros.
REQ-012 pe_sign_x bit i = x_signed AND (brick i is the MSB brick of its operand): bits 3..0 in 2b mode, bits 3 and 1 in 4b mode, bit 3 only in 8b mode. pe_sign_y follows the same rule.
REQ-013 Accumulation is 20-bit two's complement and wraps on overflow; no saturation.
REQ-014 cfg_valid outside IDLE is ignored, with cfg_ready=0. in_valid outside RUN is ignored, with in_ready=0.
REQ-015 len=0 is a single-beat job: out_sum equals that beat's pe_sum.

Reset
REQ-016 Reset asserted (reset=0) forces the following regardless of state, including mid-job; the partial job is discarded:
- FSM to IDLE.
- acc, beat counter, beat_d, pe_x, pe_y, pe_signal, pe_sum_signal, pe_sign_x, pe_sign_y, pe_previous_sum and out_sum to 0.
- out_valid, in_ready and busy to 0.
- cfg_ready to 1.
REQ-017 The first job is accepted on the first clk edge after reset deasserts.

Configuration
REQ-018 Macro PE_CTRL_PERF_EN, when defined, adds two outputs and a clear input:
- perf_beats (32): count of issued beats.
- perf_stall (32): count of RUN cycles with in_valid=0.
- perf_clr (in, 1): synchronous clear of both counters.
- Both counters wrap and reset to 0.
REQ-019 Without PE_CTRL_PERF_EN these ports and counters do not exist, and all other behaviour is identical.

Structure
REQ-020 Package pe_ctrl_pkg holds:
- Mode encodings (MODE_2B, MODE_4B, MODE_8B).
- The FSM state enum.
- SHIFT_LUT[mode] (32-bit) and SUM_LUT[mode] (8-bit) constants, matching the fusion unit's shift and adder-tree encodings.
- The sign-mask constants.
REQ-021 A single sub-module, pe_ctrl_acc, holds beat_d, first-beat tracking, acc and the previous_sum mux. The FSM and issue logic stay in pe_ctrl.

Verification
REQ-022 2b mode, len=0, one beat with a model pe_sum of 0x00123 -> pe_signal=0, pe_sum_signal=0, pe_previous_sum=0 during beat_d, out_sum=0x00123.
REQ-023 8b signed mode, len=3, beats back-to-back, model sums 5, -2, 7, 1 -> pe_sign_x=pe_sign_y=4'b1000; out_valid is 2 cycles after the last beat; out_sum=11.
REQ-024 4b mode, len=2, in_valid low for 3 cycles between beats -> acc unchanged during the bubbles; out_sum correct; with PE_CTRL_PERF_EN, perf_stall=3 and perf_beats=3.
REQ-025 Overflow: two beats of 0x7FFFF -> out_sum=0xFFFFE (wraps).
REQ-026 reset pulsed low during beat 2 of a len=5 job -> all outputs at their reset values; a new len=0 job afterwards returns its own pe_sum.
REQ-027 out_ready held low for 4 cycles in DONE -> out_valid and out_sum stable; cfg_ready=0; cfg_valid ignored until the handshake completes.

Source files
------------

// File: rtl/pe_ctrl_pkg.sv
// pe_ctrl_pkg: mode encodings, FSM states and per-mode control LUTs for the PE controller.
// The reserved mode (3) entries mirror 8b so a raw 2-bit mode can index safely.
package pe_ctrl_pkg;

  localparam logic [1:0] MODE_2B = 2'd0;
  localparam logic [1:0] MODE_4B = 2'd1;
  localparam logic [1:0] MODE_8B = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [31:0] SHIFT_LUT [0:3] = '{32'h0000_0000, 32'h0000_0A0A, 32'h0F0F_0F0F, 32'h0F0F_0F0F};
  localparam logic [7:0]  SUM_LUT   [0:3] = '{8'h00, 8'h33, 8'h77, 8'h77};

  // One bit per brick row, set where that brick holds an operand's MSBs.
  localparam logic [3:0]  SIGN_MASK [0:3] = '{4'b1111, 4'b1010, 4'b1000, 4'b1000};

  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    return (mode == 2'd3) ? MODE_8B : mode;
  endfunction

endpackage

// File: rtl/pe_ctrl_acc.sv
// pe_ctrl_acc: aligns beat issue with fusion-unit latency, tracks the first beat
// of a job and holds the 20-bit wrapping accumulator feeding pe_previous_sum.
module pe_ctrl_acc (
  input  logic        clk,
  input  logic        reset,
  input  logic        beat,
  input  logic        first,
  input  logic [19:0] pe_sum,
  output logic [19:0] previous_sum
);

  logic        beat_d;
  logic        first_d;
  logic [19:0] acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_d  <= 1'b0;
      first_d <= 1'b0;
      acc     <= '0;
    end else begin
      beat_d <= beat;
      if (beat)
        first_d <= first;
      if (beat_d)
        acc <= pe_sum;
    end
  end

  // The first beat of a job must not see the previous job's total.
  assign previous_sum = (beat_d && first_d) ? 20'd0 : acc;

endmodule

// File: rtl/pe_ctrl.sv
// pe_ctrl: job FSM and operand issue for the bit-fusion PE.
// Define PE_CTRL_PERF_EN to add the perf_beats/perf_stall counters and perf_clr.
module pe_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic             cfg_x_signed,
  input  logic             cfg_y_signed,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  output logic [31:0]      pe_x,
  output logic [31:0]      pe_y,
  output logic [3:0]       pe_sign_x,
  output logic [3:0]       pe_sign_y,
  output logic [31:0]      pe_signal,
  output logic [7:0]       pe_sum_signal,
  output logic [19:0]      pe_previous_sum,
  input  logic [19:0]      pe_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [19:0]      out_sum,
  output logic             busy
`ifdef PE_CTRL_PERF_EN
  ,
  input  logic             perf_clr,
  output logic [31:0]      perf_beats,
  output logic [31:0]      perf_stall
`endif
);

  state_e           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt;
  logic [1:0]       mode;
  logic             beat;
  logic             first;

  assign mode  = norm_mode(cfg_mode);
  assign beat  = in_valid && in_ready;
  assign first = (beat_cnt == '0);
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cfg_ready     <= 1'b1;
      in_ready      <= 1'b0;
      out_valid     <= 1'b0;
      out_sum       <= '0;
      len_q         <= '0;
      beat_cnt      <= '0;
      pe_x          <= '0;
      pe_y          <= '0;
      pe_signal     <= '0;
      pe_sum_signal <= '0;
      pe_sign_x     <= '0;
      pe_sign_y     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            state         <= RUN;
            cfg_ready     <= 1'b0;
            in_ready      <= 1'b1;
            len_q         <= cfg_len;
            beat_cnt      <= '0;
            pe_signal     <= SHIFT_LUT[mode];
            pe_sum_signal <= SUM_LUT[mode];
            pe_sign_x     <= cfg_x_signed ? SIGN_MASK[mode] : 4'b0000;
            pe_sign_y     <= cfg_y_signed ? SIGN_MASK[mode] : 4'b0000;
          end
        end
        RUN: begin
          if (beat) begin
            pe_x     <= in_x;
            pe_y     <= in_y;
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == len_q) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        // The last beat's result arrives this cycle, so it is also the final total.
        DRAIN: begin
          state     <= DONE;
          out_valid <= 1'b1;
          out_sum   <= pe_sum;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            cfg_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  pe_ctrl_acc u_acc (
    .clk          (clk),
    .reset        (reset),
    .beat         (beat),
    .first        (first),
    .pe_sum       (pe_sum),
    .previous_sum (pe_previous_sum)
  );

`ifdef PE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_beats <= '0;
      perf_stall <= '0;
    end else if (perf_clr) begin
      perf_beats <= '0;
      perf_stall <= '0;
    end else begin
      if (beat)
        perf_beats <= perf_beats + 32'd1;
      if (state == RUN && !in_valid)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_ctrl.sv
// tb_pe_ctrl: directed-vector bench for pe_ctrl; a small fusion model returns
// pe_sum = pe_previous_sum + pe_x[19:0] so each beat's contribution is its in_x.
module tb_pe_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_mode = 2'd0;
  logic        cfg_x_signed = 1'b0;
  logic        cfg_y_signed = 1'b0;
  logic [15:0] cfg_len = 16'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_x = 32'd0;
  logic [31:0] in_y = 32'd0;
  logic [31:0] pe_x, pe_y;
  logic [3:0]  pe_sign_x, pe_sign_y;
  logic [31:0] pe_signal;
  logic [7:0]  pe_sum_signal;
  logic [19:0] pe_previous_sum;
  logic [19:0] pe_sum;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [19:0] out_sum;
  logic        busy;
`ifdef PE_CTRL_PERF_EN
  logic        perf_clr = 1'b0;
  logic [31:0] perf_beats, perf_stall;
`endif

  int n_checks = 0;
  int n_fail = 0;

  pe_ctrl #(.LEN_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_mode        (cfg_mode),
    .cfg_x_signed    (cfg_x_signed),
    .cfg_y_signed    (cfg_y_signed),
    .cfg_len         (cfg_len),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_x            (in_x),
    .in_y            (in_y),
    .pe_x            (pe_x),
    .pe_y            (pe_y),
    .pe_sign_x       (pe_sign_x),
    .pe_sign_y       (pe_sign_y),
    .pe_signal       (pe_signal),
    .pe_sum_signal   (pe_sum_signal),
    .pe_previous_sum (pe_previous_sum),
    .pe_sum          (pe_sum),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_sum         (out_sum),
    .busy            (busy)
`ifdef PE_CTRL_PERF_EN
    ,
    .perf_clr        (perf_clr),
    .perf_beats      (perf_beats),
    .perf_stall      (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  always_comb pe_sum = pe_previous_sum + pe_x[19:0];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] mode, input logic xs, input logic ys, input logic [15:0] len);
    checkOutput("cfg_ready_before_job", {31'd0, cfg_ready}, 32'd1);
    cfg_valid    = 1'b1;
    cfg_mode     = mode;
    cfg_x_signed = xs;
    cfg_y_signed = ys;
    cfg_len      = len;
    tick();
    cfg_valid = 1'b0;
    checkOutput("busy_in_run", {31'd0, busy}, 32'd1);
    checkOutput("in_ready_in_run", {31'd0, in_ready}, 32'd1);
    checkOutput("cfg_ready_in_run", {31'd0, cfg_ready}, 32'd0);
  endtask

  task automatic send_beat(input logic [31:0] x, input logic [19:0] exp_prev);
    in_valid = 1'b1;
    in_x     = x;
    in_y     = ~x;
    tick();
    in_valid = 1'b0;
    checkOutput("pe_x_issue", pe_x, x);
    checkOutput("pe_y_issue", pe_y, ~x);
    checkOutput("prev_sum_issue", {12'd0, pe_previous_sum}, {12'd0, exp_prev});
  endtask

  task automatic finish_job(input string tag, input logic [19:0] exp_sum);
    int cyc;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    checkOutput({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    checkOutput({tag, "_out_sum"}, {12'd0, out_sum}, {12'd0, exp_sum});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, "_idle_out_valid"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_idle_cfg_ready"}, {31'd0, cfg_ready}, 32'd1);
    checkOutput({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_controls(input string tag, input logic [31:0] sig, input logic [7:0] ssig,
                                input logic [3:0] sx, input logic [3:0] sy);
    checkOutput({tag, "_pe_signal"}, pe_signal, sig);
    checkOutput({tag, "_pe_sum_signal"}, {24'd0, pe_sum_signal}, {24'd0, ssig});
    checkOutput({tag, "_pe_sign_x"}, {28'd0, pe_sign_x}, {28'd0, sx});
    checkOutput({tag, "_pe_sign_y"}, {28'd0, pe_sign_y}, {28'd0, sy});
  endtask

  task automatic check_reset_state(input string tag);
    checkOutput({tag, "_cfg_ready"}, {31'd0, cfg_ready}, 32'd1);
    checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_out_sum"}, {12'd0, out_sum}, 32'd0);
    checkOutput({tag, "_pe_x"}, pe_x, 32'd0);
    checkOutput({tag, "_pe_y"}, pe_y, 32'd0);
    checkOutput({tag, "_prev_sum"}, {12'd0, pe_previous_sum}, 32'd0);
    check_controls(tag, 32'd0, 8'd0, 4'd0, 4'd0);
  endtask

  initial begin
    #1 reset = 1'b0;
    #3;
    check_reset_state("reset");
    tick();
    reset = 1'b1;

    // 2b single-beat job, accepted on the first edge after reset release
    applyStimulus(2'd0, 1'b1, 1'b1, 16'd0);
    check_controls("job2b", 32'h0000_0000, 8'h00, 4'b1111, 4'b1111);
    send_beat(32'h0000_0123, 20'h00000);
    checkOutput("job2b_in_ready_drain", {31'd0, in_ready}, 32'd0);
    finish_job("job2b", 20'h00123);

    // 8b signed, back-to-back beats, then a stalled result handshake
    applyStimulus(2'd2, 1'b1, 1'b1, 16'd3);
    check_controls("job8b", 32'h0F0F_0F0F, 8'h77, 4'b1000, 4'b1000);
    send_beat(32'd5, 20'h00000);
    send_beat(32'hFFFF_FFFE, 20'h00005);
    send_beat(32'd7, 20'h00003);
    send_beat(32'd1, 20'h0000A);
    checkOutput("job8b_no_early_valid", {31'd0, out_valid}, 32'd0);
    tick();
    checkOutput("job8b_valid_2_cycles", {31'd0, out_valid}, 32'd1);
    cfg_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("hold_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("hold_out_sum", {12'd0, out_sum}, 32'h0000B);
      checkOutput("hold_cfg_ready", {31'd0, cfg_ready}, 32'd0);
      tick();
    end
    cfg_valid = 1'b0;
    finish_job("job8b", 20'h0000B);
    tick();
    checkOutput("job8b_cfg_ignored_busy", {31'd0, busy}, 32'd0);

    // 4b job with a 3-cycle bubble between the first two beats
`ifdef PE_CTRL_PERF_EN
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    checkOutput("perf_clr_beats", perf_beats, 32'd0);
    checkOutput("perf_clr_stall", perf_stall, 32'd0);
`endif
    applyStimulus(2'd1, 1'b1, 1'b0, 16'd2);
    check_controls("job4b", 32'h0000_0A0A, 8'h33, 4'b1010, 4'b0000);
    send_beat(32'd10, 20'h00000);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("bubble_acc_hold", {12'd0, pe_previous_sum}, 32'd10);
    end
    send_beat(32'd20, 20'h0000A);
    send_beat(32'hFFFF_FFFC, 20'h0001E);
    finish_job("job4b", 20'h0001A);
`ifdef PE_CTRL_PERF_EN
    checkOutput("perf_beats", perf_beats, 32'd3);
    checkOutput("perf_stall", perf_stall, 32'd3);
`endif

    // Reserved mode 3 behaves as 8b; sum wraps at 20 bits
    applyStimulus(2'd3, 1'b0, 1'b1, 16'd1);
    check_controls("job_mode3", 32'h0F0F_0F0F, 8'h77, 4'b0000, 4'b1000);
    send_beat(32'h0007_FFFF, 20'h00000);
    send_beat(32'h0007_FFFF, 20'h7FFFF);
    finish_job("overflow", 20'hFFFFE);

    // Reset pulsed during beat 2 of a len=5 job
    applyStimulus(2'd2, 1'b1, 1'b1, 16'd5);
    send_beat(32'h0000_0011, 20'h00000);
    in_valid = 1'b1;
    in_x     = 32'h0000_0022;
    #2 reset = 1'b0;
    #1;
    check_reset_state("midjob_reset");
    #2 reset = 1'b1;
    in_valid = 1'b0;
    tick();
    checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);
    applyStimulus(2'd0, 1'b0, 1'b0, 16'd0);
    send_beat(32'h0000_0456, 20'h00000);
    finish_job("post_reset", 20'h00456);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
